pdm_multi: RTL

PDM_MULTI -- requirements
Module: pdm_multi

---
 rtl/pdm_multi.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pdm_multi.sv
// pdm_multi: multi-channel first-order pulse-density modulator with
// complementary outputs and optional dead-time insertion.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           global modulator enable
//   duty_wr      write strobe for the shadow duty of channel duty_ch
//   duty_ch      channel index for duty_wr (out-of-range indices ignored)
//   duty_data    duty value written on duty_wr
//   duty_commit  copies every shadow duty into its active duty
//   pdm          per-channel high-side output (registered)
//   pdm_n        per-channel low-side output (registered)
//
// Output FSM (DEADTIME > 0), one per channel
//   state | meaning
//   LO_ON | low side driven: pdm=0, pdm_n=1
//   DEAD  | both sides off while the dead counter runs down
//   HI_ON | high side driven: pdm=1, pdm_n=0
module pdm_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEADTIME = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                duty_wr,
  input  logic [CH_W-1:0]     duty_ch,
  input  logic [WIDTH-1:0]    duty_data,
  input  logic                duty_commit,
  output logic [CHANNELS-1:0] pdm,
  output logic [CHANNELS-1:0] pdm_n
);

  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    acc_q    [CHANNELS];
  logic [WIDTH-1:0]    acc_d    [CHANNELS];
  logic [CHANNELS-1:0] raw;

  // Adding 2^WIDTH-1 rather than 2^WIDTH keeps acc inside [0, 2^WIDTH-1]
  // without wrap, so a full-scale duty gives a constant 1.
  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c] = '0;
      raw[c]   = en && (active_q[c] >= acc_q[c]);
      if (en)
        acc_d[c] = acc_q[c] + (raw[c] ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) - active_q[c];
    end
  end

  // Per-channel index decode drops duty_ch values with no matching channel.
  // The commit reads shadow_q before this edge's write lands, so a write in
  // the commit cycle stays pending for the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
        acc_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (duty_wr && (duty_ch == CH_W'(c)))
          shadow_q[c] <= duty_data;
        if (duty_commit)
          active_q[c] <= shadow_q[c];
        acc_q[c] <= acc_d[c];
      end
    end
  end

  if (DEADTIME == 0) begin : g_direct
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pdm   <= '0;
        pdm_n <= '1;
      end else begin
        pdm   <= raw;
        pdm_n <= ~raw;
      end
    end
  end else begin : g_dead
    typedef enum logic [1:0] {LO_ON, DEAD, HI_ON} state_t;

    localparam logic [3:0] DT_LOAD = 4'(DEADTIME - 1);

    state_t     state_q [CHANNELS];
    state_t     state_d [CHANNELS];
    logic [3:0] cnt_q   [CHANNELS];
    logic [3:0] cnt_d   [CHANNELS];

    // raw is only consulted at the end of DEAD, so a glitch mid-interval
    // neither shortens nor restarts it.
    always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_d[c] = state_q[c];
        cnt_d[c]   = cnt_q[c];
        case (state_q[c])
          LO_ON: if (raw[c]) begin
            state_d[c] = DEAD;
            cnt_d[c]   = DT_LOAD;
          end
          HI_ON: if (!raw[c]) begin
            state_d[c] = DEAD;
            cnt_d[c]   = DT_LOAD;
          end
          DEAD: begin
            if (cnt_q[c] == 4'd0)
              state_d[c] = raw[c] ? HI_ON : LO_ON;
            else
              cnt_d[c] = cnt_q[c] - 4'd1;
          end
          default: begin
            state_d[c] = LO_ON;
            cnt_d[c]   = '0;
          end
        endcase
      end
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state and never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int c = 0; c < CHANNELS; c++) begin
          state_q[c] <= LO_ON;
          cnt_q[c]   <= '0;
        end
        pdm   <= '0;
        pdm_n <= '1;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          state_q[c] <= state_d[c];
          cnt_q[c]   <= cnt_d[c];
          pdm[c]     <= (state_d[c] == HI_ON);
          pdm_n[c]   <= (state_d[c] == LO_ON);
        end
      end
    end
  end

endmodule
